// File: rtl/string_ato_seq_if.sv
// Handshake bundle for string_ato_seq: character stream in, converted result out.
interface string_ato_seq_if #(
  parameter int DW = 32,
  parameter int CW = 8
);
  logic [1:0]    cfg_rad;
  logic          in_vld;
  logic          in_rdy;
  logic [7:0]    in_chr;
  logic          in_lst;
  logic          out_vld;
  logic          out_rdy;
  logic [DW-1:0] out_val;
  logic [CW-1:0] out_cnt;
  logic          out_ovf;
  logic          out_err;

  modport master (
    output cfg_rad, in_vld, in_chr, in_lst, out_rdy,
    input  in_rdy, out_vld, out_val, out_cnt, out_ovf, out_err
  );

  modport slave (
    input  cfg_rad, in_vld, in_chr, in_lst, out_rdy,
    output in_rdy, out_vld, out_val, out_cnt, out_ovf, out_err
  );
endinterface

// File: rtl/string_ato_seq.sv
// Sequential ASCII-to-integer converter (dec/hex/oct/bin), one character per beat,
// result held on a valid/ready output until taken.
module string_ato_seq #(
  parameter int DW = 32,
  parameter int CW = 8
) (
  input  logic             clk,
  input  logic             rst,
  string_ato_seq_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;
  typedef enum logic [1:0] {RAD_DEC, RAD_HEX, RAD_OCT, RAD_BIN} rad_e;

  state_e        r_state, w_next;
  rad_e          r_rad, w_rad;
  logic [DW-1:0] r_acc;
  logic [CW-1:0] r_cnt;
  logic          r_ovf, r_err, r_neg;

  logic          w_beat, w_first;
  logic [DW-1:0] w_acc_b, w_acc_n;
  logic [CW-1:0] w_cnt_b, w_cnt_n;
  logic          w_ovf_b, w_ovf_n, w_err_b, w_err_n, w_neg_b, w_neg_n;
  logic          w_is_num, w_is_lo, w_is_up, w_dig_ok;
  logic [3:0]    w_dig;
  logic [DW+3:0] w_ext, w_mul, w_prod;

  assign w_beat  = bus.in_vld & bus.in_rdy;
  assign w_first = (r_state == S_IDLE);
  assign w_rad   = w_first ? rad_e'(bus.cfg_rad) : r_rad;

  // The first beat of a string starts from a clean slate instead of the previous result.
  assign w_acc_b = w_first ? '0   : r_acc;
  assign w_cnt_b = w_first ? '0   : r_cnt;
  assign w_ovf_b = w_first ? 1'b0 : r_ovf;
  assign w_err_b = w_first ? 1'b0 : r_err;
  assign w_neg_b = w_first ? 1'b0 : r_neg;

  assign w_is_num = (bus.in_chr >= "0") && (bus.in_chr <= "9");
  assign w_is_lo  = (bus.in_chr >= "a") && (bus.in_chr <= "f");
  assign w_is_up  = (bus.in_chr >= "A") && (bus.in_chr <= "F");

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    w_dig_ok = 1'b0;
    w_dig    = '0;
    if (w_is_num)     w_dig = 4'(bus.in_chr - 8'h30);
    else if (w_is_lo) w_dig = 4'(bus.in_chr - 8'h57);
    else if (w_is_up) w_dig = 4'(bus.in_chr - 8'h37);
    unique case (w_rad)
      RAD_DEC: w_dig_ok = w_is_num;
      RAD_HEX: w_dig_ok = w_is_num | w_is_lo | w_is_up;
      RAD_OCT: w_dig_ok = w_is_num && (bus.in_chr <= "7");
      default: w_dig_ok = w_is_num && (bus.in_chr <= "1");
    endcase
  end

  // Product is kept four bits wider than the result so any carry out of DW flags overflow.
  always_comb begin
    w_ext = {4'b0, w_acc_b};
    w_mul = '0;
    unique case (w_rad)
      RAD_DEC: w_mul = (w_ext << 3) + (w_ext << 1);
      RAD_HEX: w_mul = w_ext << 4;
      RAD_OCT: w_mul = w_ext << 3;
      default: w_mul = w_ext << 1;
    endcase
    w_prod = w_mul + {{DW{1'b0}}, w_dig};
  end

  always_comb begin
    w_acc_n = w_acc_b;
    w_cnt_n = w_cnt_b;
    w_ovf_n = w_ovf_b;
    w_err_n = w_err_b;
    w_neg_n = w_neg_b;
    if (!w_err_b && bus.in_chr != "_") begin
      if (bus.in_chr == "-" && w_first && w_rad == RAD_DEC) begin
        w_neg_n = 1'b1;
      end else if (w_dig_ok) begin
        w_acc_n = w_prod[DW-1:0];
        w_ovf_n = w_ovf_b | (|w_prod[DW+3:DW]);
        if (w_cnt_b != '1) w_cnt_n = w_cnt_b + CW'(1);
      end else begin
        w_err_n = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments; reset is asynchronous.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rad <= RAD_DEC;
      r_acc <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
      r_err <= 1'b0;
      r_neg <= 1'b0;
    end else if (w_beat) begin
      r_rad <= w_rad;
      r_acc <= (bus.in_lst && w_neg_n) ? -w_acc_n : w_acc_n;
      r_cnt <= w_cnt_n;
      r_ovf <= w_ovf_n;
      r_err <= w_err_n;
      r_neg <= w_neg_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE,
      S_RUN:   if (w_beat) w_next = bus.in_lst ? S_DONE : S_RUN;
      S_DONE:  if (bus.out_rdy) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.in_rdy  = (r_state != S_DONE);
    bus.out_vld = (r_state == S_DONE);
    bus.out_val = r_acc;
    bus.out_cnt = r_cnt;
    bus.out_ovf = r_ovf;
    bus.out_err = r_err;
  end

endmodule

// File: tb/tb_string_ato_seq.sv
// Self-checking bench for string_ato_seq: directed vector table, hand-written corner
// sequences, and random strings checked against a behavioural atoi model.
module tb_string_ato_seq;

  localparam int DW = 32;
  localparam int CW = 8;

  typedef struct {
    logic [1:0]  rad;
    string       s;
    logic [31:0] val;
    logic [7:0]  cnt;
    logic        ovf;
    logic        err;
    bit          jitter;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   last_wait = 0;
  logic [7:0] cur[$];
  vec_t tbl[$];

  string_ato_seq_if #(.DW(DW), .CW(CW)) bus ();

  string_ato_seq #(.DW(DW), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500_000;
    $display("FAIL timeout: bench did not finish within its time budget");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] rad, input string s, input logic [31:0] val,
                              input logic [7:0] cnt, input logic ovf, input logic err,
                              input bit jitter);
    vec_t v;
    v.rad = rad; v.s = s; v.val = val; v.cnt = cnt;
    v.ovf = ovf; v.err = err; v.jitter = jitter;
    return v;
  endfunction

  function automatic int dig_val(input logic [7:0] ch);
    string digs = "0123456789abcdef";
    logic [7:0] lc;
    lc = (ch >= "A" && ch <= "Z") ? ch + 8'd32 : ch;
    for (int k = 0; k < 16; k++) if (digs[k] == lc) return k;
    return -1;
  endfunction

  // Reference: plain atoi over the whole string with wide integer arithmetic.
  task automatic model(input logic [1:0] rad, output logic [31:0] val, output logic [7:0] cnt,
                       output logic ovf, output logic err);
    longint unsigned acc = 0;
    int radix, n = 0, d;
    bit neg = 0;
    radix = (rad == 0) ? 10 : (rad == 1) ? 16 : (rad == 2) ? 8 : 2;
    ovf = 0;
    err = 0;
    foreach (cur[i]) begin
      if (err || cur[i] == "_") continue;
      if (cur[i] == "-") begin
        if (i == 0 && radix == 10) neg = 1; else err = 1;
        continue;
      end
      d = dig_val(cur[i]);
      if (d < 0 || d >= radix) begin err = 1; continue; end
      acc = acc * longint'(radix) + longint'(d);
      if (acc > 64'hFFFF_FFFF) ovf = 1;
      acc = acc & 64'hFFFF_FFFF;
      n = (n < 255) ? n + 1 : 255;
    end
    if (neg) acc = (64'h1_0000_0000 - acc) & 64'hFFFF_FFFF;
    val = acc[31:0];
    cnt = n[7:0];
  endtask

  task automatic load(input string s);
    cur.delete();
    for (int i = 0; i < s.len(); i++) cur.push_back(s[i]);
  endtask

  // Called at a negedge; returns at the negedge after the beat was accepted.
  task automatic beat(input logic [7:0] c, input logic lst);
    int n = 0;
    bus.in_vld = 1'b1;
    bus.in_chr = c;
    bus.in_lst = lst;
    while (!bus.in_rdy && n < 20) begin
      @(negedge clk);
      n++;
    end
    last_wait = n;
    if (!bus.in_rdy) check("beat_rdy_timeout", bus.in_rdy, 1);
    @(negedge clk);
    bus.in_vld = 1'b0;
    bus.in_lst = 1'b0;
  endtask

  task automatic send(input logic [1:0] rad, input bit jitter);
    bus.cfg_rad = rad;
    for (int i = 0; i < cur.size(); i++) begin
      if (jitter) repeat ($urandom_range(0, 2)) @(negedge clk);
      beat(cur[i], i == cur.size() - 1);
      if (jitter) bus.cfg_rad = 2'($urandom);
    end
  endtask

  task automatic compare(input string name, input logic [31:0] val, input logic [7:0] cnt,
                         input logic ovf, input logic err);
    check({name, ".vld"}, bus.out_vld, 1);
    check({name, ".val"}, bus.out_val, val);
    check({name, ".cnt"}, bus.out_cnt, cnt);
    check({name, ".ovf"}, bus.out_ovf, ovf);
    check({name, ".err"}, bus.out_err, err);
  endtask

  task automatic release_out(input string name, input int hold);
    logic [31:0] v = bus.out_val;
    logic [7:0]  c = bus.out_cnt;
    logic        o = bus.out_ovf;
    logic        e = bus.out_err;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check({name, ".hold_rdy"}, bus.in_rdy, 0);
      check({name, ".hold_vld"}, bus.out_vld, 1);
      check({name, ".hold_val"}, {bus.out_val, bus.out_cnt, bus.out_ovf, bus.out_err},
            {v, c, o, e});
    end
    bus.out_rdy = 1'b1;
    @(negedge clk);
    check({name, ".drop_vld"}, bus.out_vld, 0);
    check({name, ".idle_rdy"}, bus.in_rdy, 1);
  endtask

  initial begin
    logic [31:0] m_val;
    logic [7:0]  m_cnt;
    logic        m_ovf, m_err;
    int          hold;

    bus.cfg_rad = 2'd0;
    bus.in_vld  = 1'b0;
    bus.in_chr  = 8'h00;
    bus.in_lst  = 1'b0;
    bus.out_rdy = 1'b1;

    tbl.push_back(mk(2'd0, "356",        32'd356,        8'd3,  0, 0, 0));
    tbl.push_back(mk(2'd1, "DEAD_BEEF",  32'hDEADBEEF,   8'd8,  0, 0, 1));
    tbl.push_back(mk(2'd2, "356",        32'd238,        8'd3,  0, 0, 1));
    tbl.push_back(mk(2'd3, "10100101",   32'd165,        8'd8,  0, 0, 1));
    tbl.push_back(mk(2'd0, "-42",        32'hFFFFFFD6,   8'd2,  0, 0, 0));
    tbl.push_back(mk(2'd0, "4-2",        32'd4,          8'd1,  0, 1, 0));
    tbl.push_back(mk(2'd1, "-1",         32'd0,          8'd0,  0, 1, 0));
    tbl.push_back(mk(2'd0, "12a3",       32'd12,         8'd2,  0, 1, 0));
    tbl.push_back(mk(2'd0, "4294967296", 32'd0,          8'd10, 1, 0, 0));
    tbl.push_back(mk(2'd0, "-",          32'd0,          8'd0,  0, 0, 0));
    tbl.push_back(mk(2'd1, "x",          32'd0,          8'd0,  0, 1, 0));
    tbl.push_back(mk(2'd1, "ffffffff1",  32'hFFFFFFF1,   8'd9,  1, 0, 0));

    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst.in_rdy", bus.in_rdy, 1);
    check("rst.out_vld", bus.out_vld, 0);
    check("rst.out_val", bus.out_val, 0);
    check("rst.out_cnt", bus.out_cnt, 0);
    check("rst.flags", {bus.out_ovf, bus.out_err}, 2'b00);
    rst = 1'b0;

    foreach (tbl[i]) begin
      load(tbl[i].s);
      send(tbl[i].rad, tbl[i].jitter);
      compare($sformatf("vec%0d", i), tbl[i].val, tbl[i].cnt, tbl[i].ovf, tbl[i].err);
      release_out($sformatf("vec%0d", i), 0);
    end

    // Output backpressure for five cycles, then the next string goes straight in.
    load("91");
    bus.out_rdy = 1'b0;
    send(2'd0, 0);
    compare("bp", 32'd91, 8'd2, 0, 0);
    release_out("bp", 5);
    load("5");
    send(2'd0, 0);
    check("bp.next_wait", last_wait, 0);
    compare("bp.next", 32'd5, 8'd1, 0, 0);
    release_out("bp.next", 0);

    // Asynchronous reset in the middle of "12345" discards the partial string.
    bus.cfg_rad = 2'd0;
    beat("1", 1'b0);
    beat("2", 1'b0);
    #2 rst = 1'b1;
    #1;
    check("midrst.in_rdy", bus.in_rdy, 1);
    check("midrst.out_vld", bus.out_vld, 0);
    check("midrst.out_val", bus.out_val, 0);
    check("midrst.cnt_flags", {bus.out_cnt, bus.out_ovf, bus.out_err}, 10'd0);
    @(negedge clk);
    rst = 1'b0;
    load("7");
    send(2'd0, 0);
    compare("midrst.next", 32'd7, 8'd1, 0, 0);
    release_out("midrst.next", 0);

    for (int t = 0; t < 60; t++) begin
      logic [1:0] rad = 2'($urandom);
      int len = $urandom_range(1, 12);
      int radix = (rad == 0) ? 10 : (rad == 1) ? 16 : (rad == 2) ? 8 : 2;
      cur.delete();
      if (rad == 0 && $urandom_range(0, 3) == 0) cur.push_back("-");
      for (int k = 0; k < len; k++) begin
        int r = $urandom_range(0, 99);
        int d = $urandom_range(0, radix - 1);
        logic [7:0] ch;
        if (r < 82)      ch = (d < 10) ? 8'(8'h30 + d)
                                       : ($urandom_range(0, 1) ? 8'(8'h61 + d - 10)
                                                               : 8'(8'h41 + d - 10));
        else if (r < 90) ch = "_";
        else if (r < 94) ch = "-";
        else if (r < 97) ch = "9";
        else             ch = "z";
        cur.push_back(ch);
      end
      model(rad, m_val, m_cnt, m_ovf, m_err);
      hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      bus.out_rdy = (hold == 0);
      send(rad, 1);
      compare($sformatf("rnd%0d", t), m_val, m_cnt, m_ovf, m_err);
      release_out($sformatf("rnd%0d", t), hold);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
